// File: rtl/spi_ahb_regs_pkg.sv
// Shared register-map constants for the SPI AHB register front-end.
package spi_ahb_regs_pkg;

  localparam int FIFO_DEPTH_DEF = 16;

  localparam logic [1:0] ADDR_CR  = 2'd0;
  localparam logic [1:0] ADDR_SR  = 2'd1;
  localparam logic [1:0] ADDR_DR  = 2'd2;
  localparam logic [1:0] ADDR_RSV = 2'd3;

  localparam int CR_EN       = 0;
  localparam int CR_CPOL     = 1;
  localparam int CR_CPHA     = 2;
  localparam int CR_FIRSTBIT = 3;
  localparam int CR_IRQEN    = 4;
  localparam int CR_PSC_LSB  = 8;
  localparam logic [11:0] CR_MASK = 12'hF1F;

  localparam int SR_BUSY      = 0;
  localparam int SR_TXF       = 1;
  localparam int SR_RXNE      = 2;
  localparam int SR_DONE      = 3;
  localparam int SR_TXOVR     = 4;
  localparam int SR_RXOVR     = 5;
  localparam int SR_TXCNT_LSB = 8;
  localparam int SR_RXCNT_LSB = 16;

  // Bus data-phase tracking: RD1 is the DR-read wait state, RD2 returns the RX byte.
  typedef enum logic [1:0] {PH_IDLE, PH_DATA, PH_RD1, PH_RD2} phase_t;

endpackage

// File: rtl/spi_occ_cnt.sv
// Up/down occupancy counter saturating at DEPTH and 0; updates on the next edge.
// No backpressure: an increment while full is dropped and reported on ovf.
module spi_occ_cnt #(
  parameter int DEPTH = 16,
  parameter int W     = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic [W-1:0] cnt_nxt,
  output logic         full,
  output logic         empty,
  output logic         ovf
);
  logic inc_ok;
  logic dec_ok;

  assign full   = (cnt == W'(DEPTH));
  assign empty  = (cnt == '0);
  assign inc_ok = inc & ~full;
  assign dec_ok = dec & ~empty;
  assign ovf    = inc & full;

  always_comb begin
    cnt_nxt = cnt;
    if (inc_ok && !dec_ok) cnt_nxt = cnt + W'(1);
    else if (dec_ok && !inc_ok) cnt_nxt = cnt - W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else        cnt <= cnt_nxt;
  end
endmodule

// File: rtl/spi_ahb_regs.sv
// AHB-Lite register front-end for the SPI controller: CR/SR/DR decode, FIFO shadow counters, sticky flags, IRQ.
// Zero wait states except DR reads (one wait state to fetch the RX byte); HREADYOUT is the only backpressure.
module spi_ahb_regs
  import spi_ahb_regs_pkg::*;
#(
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        HSEL,
  input  logic [3:0]  HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic        HREADY,
  input  logic [31:0] HWDATA,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic        spi_en,
  output logic        irq_en,
  output logic        cpol,
  output logic        cpha,
  output logic        firstbit,
  output logic [3:0]  psc,
  output logic        wr_txfifo,
  output logic [7:0]  wrdata,
  output logic        rd_rxfifo,
  input  logic [7:0]  rddata,
  input  logic        tr_flag,
  output logic        spi_irq
);
  phase_t           state;
  logic [1:0]       a_addr;
  logic             a_write;
  logic             rd_hit;
  logic             tr_q;
  logic [11:0]      cr_reg, cr_nxt;
  logic             done, txovr, rxovr;
  logic             done_nxt, txovr_nxt, rxovr_nxt;
  logic [31:0]      hrdata_q, rd_mux;
  logic [CNT_W-1:0] tx_cnt, tx_nxt, rx_cnt, rx_nxt;
  logic             tx_full, tx_empty, tx_ovf, rx_full, rx_empty, rx_ovf;
  logic             acc, dp, cr_wr, sr_wr, dr_wr, tr_done;
  logic             unused;

  assign acc     = HSEL & HREADY & HTRANS[1];
  assign dp      = (state == PH_DATA);
  assign cr_wr   = dp & a_write & (a_addr == ADDR_CR);
  assign sr_wr   = dp & a_write & (a_addr == ADDR_SR);
  assign dr_wr   = dp & a_write & (a_addr == ADDR_DR);
  assign tr_done = tr_flag & ~tr_q;

  spi_occ_cnt #(.DEPTH(FIFO_DEPTH), .W(CNT_W)) u_tx_cnt (
    .clk(clk), .rst_n(rst_n), .inc(dr_wr), .dec(tr_done),
    .cnt(tx_cnt), .cnt_nxt(tx_nxt), .full(tx_full), .empty(tx_empty), .ovf(tx_ovf)
  );

  spi_occ_cnt #(.DEPTH(FIFO_DEPTH), .W(CNT_W)) u_rx_cnt (
    .clk(clk), .rst_n(rst_n), .inc(tr_done), .dec(rd_rxfifo),
    .cnt(rx_cnt), .cnt_nxt(rx_nxt), .full(rx_full), .empty(rx_empty), .ovf(rx_ovf)
  );

  // Hardware set takes priority over a W1C clear in the same cycle.
  assign done_nxt  = tr_done | (done  & ~(sr_wr & HWDATA[SR_DONE]));
  assign txovr_nxt = tx_ovf  | (txovr & ~(sr_wr & HWDATA[SR_TXOVR]));
  assign rxovr_nxt = rx_ovf  | (rxovr & ~(sr_wr & HWDATA[SR_RXOVR]));
  assign cr_nxt    = cr_wr ? (HWDATA[11:0] & CR_MASK) : cr_reg;

  // Read data is built from next-state values so a read right behind a write sees it.
  always_comb begin
    rd_mux = '0;
    case (HADDR[3:2])
      ADDR_CR: rd_mux[11:0] = cr_nxt;
      ADDR_SR: begin
        rd_mux[SR_BUSY]                 = (tx_nxt != '0);
        rd_mux[SR_TXF]                  = (tx_nxt == CNT_W'(FIFO_DEPTH));
        rd_mux[SR_RXNE]                 = (rx_nxt != '0);
        rd_mux[SR_DONE]                 = done_nxt;
        rd_mux[SR_TXOVR]                = txovr_nxt;
        rd_mux[SR_RXOVR]                = rxovr_nxt;
        rd_mux[SR_TXCNT_LSB +: CNT_W]   = tx_nxt;
        rd_mux[SR_RXCNT_LSB +: CNT_W]   = rx_nxt;
      end
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= PH_IDLE;
      a_addr    <= '0;
      a_write   <= 1'b0;
      rd_hit    <= 1'b0;
      tr_q      <= 1'b0;
      cr_reg    <= '0;
      done      <= 1'b0;
      txovr     <= 1'b0;
      rxovr     <= 1'b0;
      spi_irq   <= 1'b0;
      wr_txfifo <= 1'b0;
      wrdata    <= '0;
      rd_rxfifo <= 1'b0;
      hrdata_q  <= '0;
    end else begin
      tr_q      <= tr_flag;
      cr_reg    <= cr_nxt;
      done      <= done_nxt;
      txovr     <= txovr_nxt;
      rxovr     <= rxovr_nxt;
      spi_irq   <= cr_nxt[CR_IRQEN] & done_nxt;
      wr_txfifo <= dr_wr & ~tx_full;
      if (dr_wr && !tx_full) wrdata <= HWDATA[7:0];
      rd_rxfifo <= 1'b0;
      case (state)
        PH_RD1: begin
          state <= PH_RD2;
          if (!rd_hit) hrdata_q <= '0;
        end
        default: begin
          if (state == PH_RD2 && rd_hit) hrdata_q <= {24'h0, rddata};
          if (acc) begin
            a_addr  <= HADDR[3:2];
            a_write <= HWRITE;
            if (!HWRITE && HADDR[3:2] == ADDR_DR) begin
              state     <= PH_RD1;
              rd_hit    <= ~rx_empty;
              rd_rxfifo <= ~rx_empty;
            end else begin
              state <= PH_DATA;
              if (!HWRITE) hrdata_q <= rd_mux;
            end
          end else begin
            state <= PH_IDLE;
          end
        end
      endcase
    end
  end

  assign HRDATA    = (state == PH_RD2 && rd_hit) ? {24'h0, rddata} : hrdata_q;
  assign HREADYOUT = (state != PH_RD1);
  assign HRESP     = 1'b0;
  assign spi_en    = cr_reg[CR_EN];
  assign cpol      = cr_reg[CR_CPOL];
  assign cpha      = cr_reg[CR_CPHA];
  assign firstbit  = cr_reg[CR_FIRSTBIT];
  assign irq_en    = cr_reg[CR_IRQEN];
  assign psc       = cr_reg[CR_PSC_LSB +: 4];
  assign unused    = &{1'b0, HADDR[1:0], HTRANS[0], HWDATA[31:12], tx_cnt, rx_cnt, tx_empty, rx_full};
endmodule
